// File: rtl/piano_score_counter_pkg.sv
// Shared definitions for the piano-tiles score stage.
//   state_e        : game state encoding (IDLE / PLAYING / OVER)
//   BCD_MAX_DIGIT  : largest value a BCD nibble may hold
//   LIVES_W        : width of the remaining-lives counter
package piano_score_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    OVER    = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int         LIVES_W       = 3;

endpackage

// File: rtl/piano_score_counter_bcd_digit_counter.sv
// One BCD digit of the score counter.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   clear       : synchronous clear to 0 (game start/restart)
//   inc_in      : increment request (carry from the digit below)
//   hold        : freeze the digit (score saturation at all-9s)
//   digit       : registered digit value, always 0-9
//   digit_next  : value the digit takes on the next edge
//   carry_out   : this digit rolls 9 -> 0 on this increment
module bcd_digit_counter
  import piano_score_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc_in,
  input  logic       hold,
  output logic [3:0] digit,
  output logic [3:0] digit_next,
  output logic       carry_out
);

  logic [3:0] digit_q, digit_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = 4'd0;
    end else if (inc_in && !hold) begin
      digit_d = (digit_q == BCD_MAX_DIGIT) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

  // Carry ignores hold, so the saturation decision upstream never loops back into it.
  assign carry_out  = inc_in && (digit_q == BCD_MAX_DIGIT);
  assign digit      = digit_q;
  assign digit_next = digit_d;

endmodule

// File: rtl/piano_score_counter.sv
// Game-score stage of the piano-tiles datapath.
// Counts hits as packed BCD, tracks lives, keeps the session high score
// and runs the IDLE/PLAYING/OVER game state. Inputs are levels; only their
// rising edges act. All outputs come straight from flops.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : start/restart request (rising edge)
//   hit, miss  : tile hit / miss indications (rising edge)
//   score_bcd  : current score, packed BCD, LS digit in [3:0]
//   high_bcd   : highest final score since reset, packed BCD
//   lives      : remaining lives
//   playing    : high in PLAYING
//   game_over  : high in OVER
module piano_score_counter
  import piano_score_counter_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int START_LIVES = 3,
  parameter int SAT_SCORE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hit,
  input  logic                    miss,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic [LIVES_W-1:0]      lives,
  output logic                    playing,
  output logic                    game_over
);

  localparam int SW = 4 * NUM_DIGITS;

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SW-1:0]      high_q, high_d;
  logic               playing_q, playing_d;
  logic               game_over_q, game_over_d;
  logic               start_q, hit_q, miss_q;

  logic [SW-1:0] score_cur, score_nxt;
  logic          start_edge, hit_edge, miss_edge;
  logic          score_inc, overflow, sat_hold;

  assign start_edge = start & ~start_q;
  assign hit_edge   = hit & ~hit_q;
  assign miss_edge  = miss & ~miss_q;

  // A start edge takes priority: it restarts the game and swallows a coincident hit.
  assign score_inc = (state_q == PLAYING) && hit_edge && !start_edge;

  // Overflow out of the top digit means the score is all-9s and incrementing.
  assign sat_hold = (SAT_SCORE != 0) && overflow;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic inc_k, carry_k;
    if (k == 0) begin : g_lsd
      assign inc_k = score_inc;
    end else begin : g_upper
      assign inc_k = g_digit[k-1].carry_k;
    end
    bcd_digit_counter u_digit (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_edge),
      .inc_in    (inc_k),
      .hold      (sat_hold),
      .digit     (score_cur[4*k +: 4]),
      .digit_next(score_nxt[4*k +: 4]),
      .carry_out (carry_k)
    );
  end

  assign overflow = g_digit[NUM_DIGITS-1].carry_k;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    high_d  = high_q;
    if (start_edge) begin
      state_d = PLAYING;
      lives_d = LIVES_W'(START_LIVES);
    end else if ((state_q == PLAYING) && miss_edge && (lives_q != '0)) begin
      lives_d = lives_q - LIVES_W'(1);
      if (lives_q == LIVES_W'(1)) begin
        state_d = OVER;
        // Packed BCD with every nibble in 0-9 orders exactly like the number,
        // so an unsigned compare is the MS-digit-first compare. score_nxt
        // includes a hit landing on the same edge as the final miss.
        if (score_nxt > high_q) high_d = score_nxt;
      end
    end
    playing_d   = (state_d == PLAYING);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lives_q     <= '0;
      high_q      <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      // History starts high so a level held through reset is not an edge.
      start_q     <= 1'b1;
      hit_q       <= 1'b1;
      miss_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      high_q      <= high_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      start_q     <= start;
      hit_q       <= hit;
      miss_q      <= miss;
    end
  end

  assign score_bcd = score_cur;
  assign high_bcd  = high_q;
  assign lives     = lives_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;

endmodule

// File: doc/piano_score_counter.md
Name: piano_score_counter

Overview:
- Game-score stage of the piano-tiles datapath. Counts tile hits and misses and holds the score as packed BCD digits. Tracks remaining lives, keeps a session high score, and runs the IDLE/PLAYING/OVER game state.
- Its digit nibbles drive the 7-segment hex decoder instances directly, one 4-bit nibble per display. Each nibble is always in the range 0-9.

Parameters:
- NUM_DIGITS, 4, number of BCD score digits (1..6); digit k occupies bits [4k+3:4k].
- START_LIVES, 3, lives loaded at game start (1..7).
- SAT_SCORE, 1, 1 = score saturates at all-9s; 0 = score wraps to 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start/restart request, level; the rising edge is used.
- hit  in  1  tile-hit indication from the tile-checker, level; the rising edge is used.
- miss  in  1  tile-miss indication, level; the rising edge is used.
- score_bcd  out  4*NUM_DIGITS  current score, packed BCD, least-significant digit in [3:0].
- high_bcd  out  4*NUM_DIGITS  highest final score since reset, packed BCD.
- lives  out  3  remaining lives.
- playing  out  1  high in PLAYING.
- game_over  out  1  high in OVER.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: score_bcd=0, high_bcd=0, lives=0, state=IDLE, playing=0, game_over=0. The edge-detect history registers for start/hit/miss reset to 1, so an input held high through reset does not produce an edge.
- Edge detection:
  - Each of start/hit/miss has a 1-flop history register.
  - The edge term is x & ~x_q. It acts on the same clock edge, so the output changes 1 cycle after the input first goes high.
  - A held level produces exactly one event.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States:
  - IDLE: start edge -> PLAYING; score cleared to 0, lives=START_LIVES. hit/miss ignored.
  - PLAYING:
    - hit edge -> score +1 in BCD. A digit at 9 rolls to 0 and carries into the next digit within the same cycle.
    - At all-9s: SAT_SCORE=1 holds the value; SAT_SCORE=0 wraps to 0.
    - miss edge -> lives -1. If lives was 1, go to OVER on the same edge.
    - hit and miss edges in the same cycle: both apply. The score increments even when that miss ends the game.
    - A start edge in PLAYING restarts the game: score=0, lives=START_LIVES, state stays PLAYING. high_bcd is not updated.
  - OVER:
    - On entry (same edge as the final miss): if the final score > high_bcd, high_bcd <= final score.
    - The comparison is BCD digit-wise, most-significant digit first, equivalent to a numeric compare.
    - hit/miss ignored; score held for display.
    - start edge -> PLAYING with the same initialisation as from IDLE.
- lives never underflows; the decrement happens only when lives >= 1.
- Reset asserted mid-game returns to the reset values on that edge; high_bcd is also cleared.
- Outputs: playing = (state==PLAYING); game_over = (state==OVER).

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, PLAYING=2'd1, OVER=2'd2.
  - BCD_MAX_DIGIT=4'd9.
  - the lives width constant (3).
- One natural sub-module: bcd_digit_counter, a single digit with inc_in, carry_out, sync clear, and saturate-hold input.
  - NUM_DIGITS instances are chained through a generate loop.
  - The top level keeps the FSM, edge detection, lives, and the high-score compare/load.

Test Plan:
- Reset then start edge -> 1 cycle later playing=1, lives=3, score_bcd=16'h0000; hold start high 10 cycles -> no further restart.
- In PLAYING, apply 0x10 hit pulses (16 pulses) -> score_bcd=16'h0016; 109 more pulses (125 total) -> 16'h0125. No nibble ever exceeds 9.
- Preload score to 16'h9999 with 9999 hits, then 1 hit: SAT_SCORE=1 -> 16'h9999; SAT_SCORE=0 -> 16'h0000.
- Score 42, apply 3 miss pulses -> lives 3,2,1,0; game_over=1 on the cycle after the 3rd miss; high_bcd=16'h0042. Further hits leave the score at 0042.
- Same cycle as the final miss, also raise hit (score 7->8) -> game_over=1, score_bcd=16'h0008, high_bcd updates to 0008 only if the prior high was < 8. Second game ending at 5 with high 42 -> high_bcd stays 16'h0042.
- Mid-game (score 0013, lives 2) assert reset for 1 cycle -> next cycle all outputs at reset values, high_bcd=0. hit held high across reset release -> no increment after a later start.
